// File: rtl/ptch_fusion_pkg.sv
// rtl/ptch_fusion_pkg.sv - shared state type and default constants for the pitch fusion filter
package ptch_fusion_pkg;

    typedef enum logic [1:0] {
        ST_CAL  = 2'd0,
        ST_SEED = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int          FUSE_STEP_DFLT     = 1024;
    localparam int          ACC_GAIN_DFLT      = 327;
    localparam int          ACC_SHIFT_DFLT     = 13;
    localparam logic [15:0] AZ_OFFSET_DFLT     = 16'h00A0;
    localparam logic [15:0] RT_OFFSET_RST_DFLT = 16'h0050;

endpackage

// File: rtl/ptch_fusion_filter_rate_offset_cal.sv
// rtl/ptch_fusion_filter_rate_offset_cal.sv - averages 2^CAL_LOG2 gyro samples into the rate offset
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   vld         sample strobe (only asserted by the parent while calibrating)
//   ptch_rt     signed gyro rate sample
//   clr         restart the average; a vld in the same cycle is discarded
//   done        combinational pulse on the sample that completes the average
//   rt_offset   learned offset, RT_OFFSET_RST until the first average completes
module rate_offset_cal #(
    parameter int             W             = 16,
    parameter int             CAL_LOG2      = 4,
    parameter logic [W-1:0]   RT_OFFSET_RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vld,
    input  logic [W-1:0] ptch_rt,
    input  logic         clr,
    output logic         done,
    output logic [W-1:0] rt_offset
);

    logic [CAL_LOG2-1:0]          cnt;
    logic signed [W+CAL_LOG2-1:0] cal_acc;
    logic signed [W+CAL_LOG2-1:0] acc_nxt;

    // The accumulator is wide enough for 2^CAL_LOG2 full-scale samples.
    assign acc_nxt = cal_acc + $signed({{CAL_LOG2{ptch_rt[W-1]}}, ptch_rt});

    // cnt counts completed samples; the all-ones value means this vld is the last.
    assign done = vld && !clr && (&cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            cal_acc   <= '0;
            rt_offset <= RT_OFFSET_RST;
        end else if (clr) begin
            cnt     <= '0;
            cal_acc <= '0;
        end else if (vld) begin
            if (&cnt) begin
                // Arithmetic shift floors the average toward minus infinity.
                rt_offset <= W'(acc_nxt >>> CAL_LOG2);
                cnt       <= '0;
                cal_acc   <= '0;
            end else begin
                cnt     <= cnt + 1'b1;
                cal_acc <= acc_nxt;
            end
        end
    end

endmodule

// File: rtl/ptch_fusion_filter.sv
// rtl/ptch_fusion_filter.sv - complementary pitch filter with self-calibrating gyro offset
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   vld         new sample strobe
//   ptch_rt     signed gyro pitch rate
//   AZ          signed accelerometer Z
//   cal_req     level request to (re)calibrate the gyro offset
//   ptch        signed fused pitch (integer part of the integrator)
//   ptch_vld    one-cycle pulse after each seed/run update
//   cal_busy    high while calibrating or waiting to seed
//   rt_offset   current learned gyro offset
module ptch_fusion_filter
    import ptch_fusion_pkg::*;
#(
    parameter int           W             = 16,
    parameter int           INT_FRAC      = 11,
    parameter int           FUSE_STEP     = FUSE_STEP_DFLT,
    parameter int           ACC_GAIN      = ACC_GAIN_DFLT,
    parameter int           ACC_SHIFT     = ACC_SHIFT_DFLT,
    parameter logic [W-1:0] AZ_OFFSET     = W'(AZ_OFFSET_DFLT),
    parameter logic [W-1:0] RT_OFFSET_RST = W'(RT_OFFSET_RST_DFLT),
    parameter int           CAL_LOG2      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vld,
    input  logic [W-1:0] ptch_rt,
    input  logic [W-1:0] AZ,
    input  logic         cal_req,
    output logic [W-1:0] ptch,
    output logic         ptch_vld,
    output logic         cal_busy,
    output logic [W-1:0] rt_offset
);

    localparam int IW = W + INT_FRAC;

    // Integrator limits expressed in the two-bit-wider sum domain.
    localparam logic signed [IW+1:0] SAT_MAX  = {3'b000, {(IW-1){1'b1}}};
    localparam logic signed [IW+1:0] SAT_MIN  = {3'b111, {(IW-1){1'b0}}};
    localparam logic signed [IW+1:0] FUSE_POS = (IW+2)'(FUSE_STEP);
    localparam logic signed [IW+1:0] FUSE_NEG = -FUSE_POS;
    localparam logic [2*W+1:0]       GAIN_X   = (2*W+2)'(ACC_GAIN);

    state_t state, state_nxt;

    logic                   cal_done;
    logic                   upd_seed;
    logic                   upd_run;
    logic signed [W:0]      az_c;
    logic signed [2*W+1:0]  acc_prod;
    logic signed [W-1:0]    ptch_acc;
    logic signed [W:0]      rt_c;
    logic                   fuse_up;
    logic signed [IW-1:0]   integ;
    logic signed [IW+1:0]   sum;
    logic signed [IW-1:0]   sum_sat;

    // Accelerometer pitch: both operands are sign-extended to the full product
    // width, so the low bits of the unsigned product are the signed product.
    assign az_c     = $signed({AZ[W-1], AZ}) - $signed({AZ_OFFSET[W-1], AZ_OFFSET});
    assign acc_prod = $signed({{(W+1){az_c[W]}}, az_c} * GAIN_X);
    assign ptch_acc = W'(acc_prod >>> ACC_SHIFT);

    // One extra bit keeps the offset-corrected rate from wrapping.
    assign rt_c = $signed({ptch_rt[W-1], ptch_rt}) - $signed({rt_offset[W-1], rt_offset});

    assign ptch    = integ[IW-1:INT_FRAC];
    assign fuse_up = ptch_acc > $signed(ptch);

    assign sum = $signed({{2{integ[IW-1]}}, integ})
               - $signed({{(IW+1-W){rt_c[W]}}, rt_c})
               + (fuse_up ? FUSE_POS : FUSE_NEG);

    always_comb begin
        sum_sat = sum[IW-1:0];
        if (sum > SAT_MAX) begin
            sum_sat = SAT_MAX[IW-1:0];
        end else if (sum < SAT_MIN) begin
            sum_sat = SAT_MIN[IW-1:0];
        end
    end

    rate_offset_cal #(
        .W             (W),
        .CAL_LOG2      (CAL_LOG2),
        .RT_OFFSET_RST (RT_OFFSET_RST)
    ) u_cal (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld       (vld && (state == ST_CAL)),
        .ptch_rt   (ptch_rt),
        .clr       (cal_req),
        .done      (cal_done),
        .rt_offset (rt_offset)
    );

    always_comb begin
        state_nxt = state;
        upd_seed  = 1'b0;
        upd_run   = 1'b0;
        case (state)
            ST_CAL: begin
                if (cal_done) begin
                    state_nxt = ST_SEED;
                end
            end
            ST_SEED: begin
                if (cal_req) begin
                    state_nxt = ST_CAL;
                end else if (vld) begin
                    upd_seed  = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cal_req) begin
                    state_nxt = ST_CAL;
                end else if (vld) begin
                    upd_run = 1'b1;
                end
            end
            default: state_nxt = ST_CAL;
        endcase
    end

    assign cal_busy = (state != ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_CAL;
            integ    <= '0;
            ptch_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptch_vld <= upd_seed || upd_run;
            if (upd_seed) begin
                integ <= {ptch_acc, {INT_FRAC{1'b0}}};
            end else if (upd_run) begin
                integ <= sum_sat;
            end
        end
    end

endmodule

// File: tb/tb_ptch_fusion_filter.sv
// tb/tb_ptch_fusion_filter.sv - self-checking bench for ptch_fusion_filter
module tb_ptch_fusion_filter;

    localparam int M_CAL  = 0;
    localparam int M_SEED = 1;
    localparam int M_RUN  = 2;
    localparam longint LIM = 64'sd1 <<< 26;

    logic        clk;
    logic        rst_n;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        cal_req;
    logic [15:0] ptch;
    logic        ptch_vld;
    logic        cal_busy;
    logic [15:0] rt_offset;

    ptch_fusion_filter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld       (vld),
        .ptch_rt   (ptch_rt),
        .AZ        (AZ),
        .cal_req   (cal_req),
        .ptch      (ptch),
        .ptch_vld  (ptch_vld),
        .cal_busy  (cal_busy),
        .rt_offset (rt_offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    int     m_state;
    longint m_integ;
    longint m_acc;
    int     m_cnt;
    int     m_off;
    bit     exp_pulse;
    logic [15:0] sb[$];

    typedef struct {
        bit          v;
        logic [15:0] rt;
        logic [15:0] az;
        bit          cr;
        bit          exp_pv;
        logic [15:0] exp_ptch;
        bit          exp_busy;
        logic [15:0] exp_off;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic longint s16(input logic [15:0] x);
        return longint'($signed(x));
    endfunction

    function automatic logic [15:0] lo16(input longint x);
        logic [63:0] t;
        t = x;
        return t[15:0];
    endfunction

    task automatic model_reset();
        m_state = M_CAL;
        m_integ = 0;
        m_acc   = 0;
        m_cnt   = 0;
        m_off   = 16'h0050;
        exp_pulse = 1'b0;
        sb.delete();
    endtask

    task automatic model_update(input bit v, input logic [15:0] rt, input logic [15:0] az, input bit cr);
        longint pa, cur, rtc, fuse, s;
        pa  = ((s16(az) - 160) * 327) >>> 13;
        pa  = s16(lo16(pa));
        cur = m_integ >>> 11;
        exp_pulse = 1'b0;
        if (cr) begin
            m_state = M_CAL;
            m_cnt = 0;
            m_acc = 0;
        end else if (v) begin
            if (m_state == M_CAL) begin
                m_acc += s16(rt);
                m_cnt++;
                if (m_cnt == 16) begin
                    m_off   = int'(m_acc >>> 4);
                    m_cnt   = 0;
                    m_acc   = 0;
                    m_state = M_SEED;
                end
            end else if (m_state == M_SEED) begin
                m_integ   = pa * 2048;
                m_state   = M_RUN;
                exp_pulse = 1'b1;
            end else begin
                rtc  = s16(rt) - longint'(m_off);
                fuse = (pa > cur) ? 1024 : -1024;
                s    = m_integ - rtc + fuse;
                if (s > LIM - 1) s = LIM - 1;
                if (s < -LIM) s = -LIM;
                m_integ   = s;
                exp_pulse = 1'b1;
            end
            if (exp_pulse) sb.push_back(lo16(m_integ >>> 11));
        end
    endtask

    task automatic check_outputs();
        logic [15:0] e;
        chk("cal_busy", {31'd0, cal_busy}, {31'd0, m_state != M_RUN});
        chk("rt_offset", {16'd0, rt_offset}, {16'd0, lo16(longint'(m_off))});
        chk("ptch", {16'd0, ptch}, {16'd0, lo16(m_integ >>> 11)});
        chk("ptch_vld", {31'd0, ptch_vld}, {31'd0, exp_pulse});
        if (ptch_vld && sb.size() > 0) begin
            e = sb.pop_front();
            chk("ptch_on_vld", {16'd0, ptch}, {16'd0, e});
        end else if (exp_pulse && sb.size() > 0) begin
            void'(sb.pop_front());
        end
    endtask

    task automatic step(input bit v, input logic [15:0] rt, input logic [15:0] az, input bit cr);
        @(negedge clk);
        vld = v;
        ptch_rt = rt;
        AZ = az;
        cal_req = cr;
        model_update(v, rt, az, cr);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        vld = 1'b0;
        cal_req = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_ptch", {16'd0, ptch}, 32'd0);
        chk("rst_ptch_vld", {31'd0, ptch_vld}, 32'd0);
        chk("rst_cal_busy", {31'd0, cal_busy}, 32'd1);
        chk("rst_rt_offset", {16'd0, rt_offset}, 32'h0050);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] held;
        bit          wrapped;
        rst_n = 1'b0;
        vld = 1'b0;
        ptch_rt = '0;
        AZ = '0;
        cal_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Nominal calibration, seed and alternating fuse sign.
        for (int i = 0; i < 16; i++)
            vecs[i] = '{1'b1, 16'h0050, 16'h00A0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0050};
        vecs[16] = '{1'b1, 16'h0050, 16'h00A0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0050};
        vecs[17] = '{1'b1, 16'h0050, 16'h00A0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0050};
        vecs[18] = '{1'b1, 16'h0050, 16'h00A0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0050};
        vecs[19] = '{1'b1, 16'h0050, 16'h00A0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0050};
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].v, vecs[i].rt, vecs[i].az, vecs[i].cr);
            chk($sformatf("tbl%0d_ptch_vld", i), {31'd0, ptch_vld}, {31'd0, vecs[i].exp_pv});
            chk($sformatf("tbl%0d_ptch", i), {16'd0, ptch}, {16'd0, vecs[i].exp_ptch});
            chk($sformatf("tbl%0d_busy", i), {31'd0, cal_busy}, {31'd0, vecs[i].exp_busy});
            chk($sformatf("tbl%0d_off", i), {16'd0, rt_offset}, {16'd0, vecs[i].exp_off});
        end

        // Alternating calibration samples, then an accel-seeded start.
        step(1'b0, 16'h0050, 16'h00A0, 1'b1);
        for (int i = 0; i < 16; i++)
            step(1'b1, (i % 2 == 0) ? 16'h0060 : 16'h0040, 16'h00A0, 1'b0);
        chk("alt_off", {16'd0, rt_offset}, 32'h0050);
        step(1'b1, 16'h0050, 16'h0488, 1'b0);
        chk("seed39", {16'd0, ptch}, 32'd39);
        for (int i = 0; i < 6; i++) step(1'b1, 16'h0050, 16'h0488, 1'b0);

        // Positive saturation, then the mirror case.
        wrapped = 1'b0;
        for (int i = 0; i < 2300; i++) begin
            step(1'b1, 16'h8000, 16'h7FFF, 1'b0);
            if (i > 1000 && ptch[15]) wrapped = 1'b1;
        end
        chk("sat_hi", {16'd0, ptch}, 32'h7FFF);
        chk("sat_hi_nowrap", {31'd0, wrapped}, 32'd0);
        wrapped = 1'b0;
        for (int i = 0; i < 4500; i++) begin
            step(1'b1, 16'h7FFF, 16'h8000, 1'b0);
            if (i > 3000 && !ptch[15]) wrapped = 1'b1;
        end
        chk("sat_lo", {16'd0, ptch}, 32'h8000);
        chk("sat_lo_nowrap", {31'd0, wrapped}, 32'd0);

        // Recalibration request during RUN, plus a restart while calibrating.
        step(1'b1, 16'h0050, 16'h0488, 1'b0);
        held = ptch;
        step(1'b1, 16'h0050, 16'h0488, 1'b1);
        chk("creq_busy", {31'd0, cal_busy}, 32'd1);
        chk("creq_no_vld", {31'd0, ptch_vld}, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0030, 16'h0488, 1'b0);
        step(1'b1, 16'h0030, 16'h0488, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b1, 16'h0070, 16'h0488, 1'b0);
        chk("restart_busy", {31'd0, cal_busy}, 32'd1);
        chk("restart_off_kept", {16'd0, rt_offset}, 32'h0050);
        step(1'b1, 16'h0070, 16'h0488, 1'b0);
        chk("recal_off", {16'd0, rt_offset}, 32'h0070);
        chk("frozen_ptch", {16'd0, ptch}, {16'd0, held});
        step(1'b0, 16'h0070, 16'h0488, 1'b0);
        step(1'b1, 16'h0070, 16'h0488, 1'b0);
        chk("reseed_ptch", {16'd0, ptch}, 32'd39);

        // Reset part-way through a calibration.
        step(1'b0, 16'h0100, 16'h00A0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 16'h0100, 16'h00A0, 1'b0);
        do_reset();
        for (int i = 0; i < 15; i++) step(1'b1, 16'h0100, 16'h00A0, 1'b0);
        chk("post_rst_busy", {31'd0, cal_busy}, 32'd1);
        chk("post_rst_off", {16'd0, rt_offset}, 32'h0050);
        step(1'b1, 16'h0100, 16'h00A0, 1'b0);
        chk("post_rst_cal_off", {16'd0, rt_offset}, 32'h0100);
        step(1'b1, 16'h0100, 16'h00A0, 1'b0);
        chk("post_rst_seed_vld", {31'd0, ptch_vld}, 32'd1);

        // Irregular vld spacing including back-to-back samples.
        for (int i = 0; i < 60; i++) begin
            int gap;
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) step(1'b0, 16'h0000, 16'h0000, 1'b0);
            step(1'b1, 16'(16'h00E0 + $urandom_range(0, 64)), 16'($urandom_range(0, 16'hFFFF)), 1'b0);
        end
        step(1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
